psl_command_responder: RTL and testbench

PSL_COMMAND_RESPONDER -- requirements
Module: psl_command_responder

---
 rtl/psl_command_responder_if.sv | 45 ++++
 rtl/psl_command_responder.sv | 184 ++++++++++++++++++
 tb/tb_psl_command_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psl_command_responder_if.sv
// rtl/psl_command_responder_if.sv - AFU-facing command, buffer and response bus of the PSL command responder
interface psl_command_responder_if;
  logic         command_valid;
  logic [7:0]   command_tag;
  logic [12:0]  command_code;
  logic [63:0]  command_address;
  logic [11:0]  command_size;
  logic [7:0]   room;
  logic         buffer_read_valid;
  logic [7:0]   buffer_read_tag;
  logic [5:0]   buffer_read_address;
  logic [511:0] buffer_read_data;
  logic         buffer_write_valid;
  logic [7:0]   buffer_write_tag;
  logic [5:0]   buffer_write_address;
  logic [511:0] buffer_write_data;
  logic         response_valid;
  logic [7:0]   response_tag;
  logic [7:0]   response_code;
  logic [8:0]   response_credits;
  logic         inject_valid;
  logic [7:0]   inject_code;
  logic         write_capture_valid;
  logic [511:0] write_capture_data;
  logic         credit_error;
  logic [7:0]   fifo_count;

  modport slave (
    input  command_valid, command_tag, command_code, command_address, command_size,
    input  buffer_read_data, inject_valid, inject_code,
    output room, buffer_read_valid, buffer_read_tag, buffer_read_address,
    output buffer_write_valid, buffer_write_tag, buffer_write_address, buffer_write_data,
    output response_valid, response_tag, response_code, response_credits,
    output write_capture_valid, write_capture_data, credit_error, fifo_count
  );

  modport master (
    output command_valid, command_tag, command_code, command_address, command_size,
    output buffer_read_data, inject_valid, inject_code,
    input  room, buffer_read_valid, buffer_read_tag, buffer_read_address,
    input  buffer_write_valid, buffer_write_tag, buffer_write_address, buffer_write_data,
    input  response_valid, response_tag, response_code, response_credits,
    input  write_capture_valid, write_capture_data, credit_error, fifo_count
  );
endinterface

// File: rtl/psl_command_responder.sv
// rtl/psl_command_responder.sv - PSL-side command responder: credit FIFO, halfline transfer FSM, response generation
module psl_command_responder #(
  parameter int CREDITS = 64,
  parameter int BRLAT   = 2
) (
  input  logic             clock,
  input  logic             rstn,
  psl_command_responder_if.slave bus
);
  localparam logic [12:0] C_READ    = 13'h0A00;
  localparam logic [12:0] C_WRITE   = 13'h0D00;
  localparam logic [12:0] C_RESTART = 13'h0001;
  localparam logic [7:0]  R_DONE    = 8'h00;
  localparam logic [7:0]  R_AERROR  = 8'h01;
  localparam logic [7:0]  R_FLUSHED = 8'h07;
  localparam logic [7:0]  R_PAGED   = 8'h0A;
  localparam int          AW        = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam logic [AW-1:0] LAST    = AW'(CREDITS - 1);

  typedef struct packed {
    logic [7:0]  tag;
    logic [12:0] code;
    logic [63:0] addr;
    logic [11:0] size;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_BWRITE0, S_BWRITE1, S_BREAD0, S_BREAD1, S_BWAIT, S_RESP
  } state_t;

  cmd_t          r_mem [CREDITS];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_count, r_room;
  logic          r_credit_error;
  cmd_t          r_cmd;
  state_t        r_state, w_next;
  logic          r_flush, r_inj_armed;
  logic [7:0]    r_inj_code;
  logic          r_resp_valid;
  logic [7:0]    r_resp_tag, r_resp_code;
  logic [BRLAT-1:0] r_cap_v, r_cap_hl;

  logic       w_push, w_pop;
  cmd_t       w_head;
  logic [7:0] w_resp_code;
  logic       w_known, w_rw;
  logic       w_brv, w_br_hl, w_bwv, w_bw_hl;
  logic       w_unused_addr_lsb;

  // No backpressure: a command with no credit left is dropped, never queued
  assign w_push = bus.command_valid && (r_room != 8'd0);
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.command_tag, bus.command_code, bus.command_address, bus.command_size};
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= 8'd0;
      r_room         <= 8'(CREDITS);
      r_credit_error <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !r_resp_valid)      r_room <= r_room - 8'd1;
      else if (!w_push && r_resp_valid) r_room <= r_room + 8'd1;
      if (bus.command_valid && (r_room == 8'd0)) r_credit_error <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_cmd <= w_head;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 8'd0) begin
          w_pop = 1'b1;
          if (r_flush && (w_head.code != C_RESTART))                 w_next = S_RESP;
          else if ((w_head.code == C_READ) && (w_head.size == 12'd128))  w_next = S_BWRITE0;
          else if ((w_head.code == C_WRITE) && (w_head.size == 12'd128)) w_next = S_BREAD0;
          else                                                        w_next = S_RESP;
        end
      end
      S_BWRITE0: w_next = S_BWRITE1;
      S_BWRITE1: w_next = S_RESP;
      S_BREAD0:  w_next = S_BREAD1;
      S_BREAD1:  w_next = S_BWAIT;
      S_BWAIT:   if (r_cap_v[BRLAT-1] && r_cap_hl[BRLAT-1]) w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rw    = (r_cmd.code == C_READ) || (r_cmd.code == C_WRITE);
    w_known = w_rw || (r_cmd.code == C_RESTART);
    if (r_inj_armed)                               w_resp_code = r_inj_code;
    else if (r_flush && (r_cmd.code != C_RESTART)) w_resp_code = R_FLUSHED;
    else if (!w_known || (w_rw && (r_cmd.size != 12'd128))) w_resp_code = R_AERROR;
    else                                           w_resp_code = R_DONE;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_tag   <= 8'd0;
      r_resp_code  <= 8'd0;
      r_flush      <= 1'b0;
      r_inj_armed  <= 1'b0;
      r_inj_code   <= 8'd0;
    end else begin
      r_resp_valid <= (r_state == S_RESP);
      r_resp_tag   <= (r_state == S_RESP) ? r_cmd.tag : 8'd0;
      r_resp_code  <= (r_state == S_RESP) ? w_resp_code : 8'd0;
      if (r_state == S_RESP) begin
        if (w_resp_code == R_PAGED)       r_flush <= 1'b1;
        else if (r_cmd.code == C_RESTART) r_flush <= 1'b0;
      end
      // A new arm in the same cycle as a response survives for the following one
      if (bus.inject_valid) begin
        r_inj_armed <= 1'b1;
        r_inj_code  <= bus.inject_code;
      end else if (r_state == S_RESP) begin
        r_inj_armed <= 1'b0;
      end
    end
  end

  assign w_brv   = (r_state == S_BREAD0) || (r_state == S_BREAD1);
  assign w_br_hl = (r_state == S_BREAD1);
  assign w_bwv   = (r_state == S_BWRITE0) || (r_state == S_BWRITE1);
  assign w_bw_hl = (r_state == S_BWRITE1);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_cap_v  <= '0;
      r_cap_hl <= '0;
    end else begin
      r_cap_v[0]  <= w_brv;
      r_cap_hl[0] <= w_br_hl;
      for (int i = 1; i < BRLAT; i++) begin
        r_cap_v[i]  <= r_cap_v[i-1];
        r_cap_hl[i] <= r_cap_hl[i-1];
      end
    end
  end

  assign w_unused_addr_lsb = r_cmd.addr[0];

  assign bus.room                 = r_room;
  assign bus.fifo_count           = r_count;
  assign bus.credit_error         = r_credit_error;
  assign bus.buffer_read_valid    = w_brv;
  assign bus.buffer_read_tag      = w_brv ? r_cmd.tag : 8'd0;
  assign bus.buffer_read_address  = {5'd0, w_br_hl};
  assign bus.buffer_write_valid   = w_bwv;
  assign bus.buffer_write_tag     = w_bwv ? r_cmd.tag : 8'd0;
  assign bus.buffer_write_address = {5'd0, w_bw_hl};
  assign bus.buffer_write_data    = w_bwv ? {8{r_cmd.addr[63:1], w_bw_hl}} : 512'd0;
  assign bus.response_valid       = r_resp_valid;
  assign bus.response_tag         = r_resp_tag;
  assign bus.response_code        = r_resp_code;
  assign bus.response_credits     = {8'd0, r_resp_valid};
  assign bus.write_capture_valid  = r_cap_v[BRLAT-1];
  assign bus.write_capture_data   = r_cap_v[BRLAT-1] ? bus.buffer_read_data : 512'd0;
endmodule

// File: tb/tb_psl_command_responder.sv
// tb/tb_psl_command_responder.sv - directed self-checking bench for psl_command_responder
module tb_psl_command_responder;
  localparam int BRLAT = 2;
  localparam logic [12:0] READ = 13'h0A00, WRITE = 13'h0D00, RESTART = 13'h0001;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   cap_cnt = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  psl_command_responder_if bus_a ();
  psl_command_responder_if bus_b ();

  psl_command_responder #(.CREDITS(64), .BRLAT(BRLAT)) u_dut (.clock(clock), .rstn(rstn), .bus(bus_a));
  psl_command_responder #(.CREDITS(4),  .BRLAT(BRLAT)) u_dut_small (.clock(clock), .rstn(rstn), .bus(bus_b));

  typedef struct { logic [7:0] tag; logic [7:0] code; logic [8:0] cred; int cyc; } resp_t;
  typedef struct { logic [7:0] tag; logic [5:0] addr; logic [511:0] data; int cyc; } bw_t;
  typedef struct { logic [7:0] tag; logic [5:0] addr; int cyc; } br_t;

  resp_t      resp_q[$];
  bw_t        bw_q[$];
  br_t        br_q[$];
  logic [7:0] resp_b_q[$];
  logic       cap_due [8];
  logic [7:0] cap_tag [8];
  logic       cap_hl  [8];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [7:0] t, input logic hl);
    return {16{8'hC3, t, 8'h5A, 7'd0, hl}};
  endfunction

  function automatic logic [511:0] bwd(input logic [63:0] a, input logic hl);
    return {8{a[63:1], hl}};
  endfunction

  // AFU model: answers each buffer read BRLAT cycles later, junk otherwise
  always @(posedge clock) begin
    #2;
    if (cap_due[cyc % 8]) bus_a.buffer_read_data = pat(cap_tag[cyc % 8], cap_hl[cyc % 8]);
    else                  bus_a.buffer_read_data = {16{32'hDEADBEEF}};
  end

  always @(negedge clock) begin
    int idx;
    idx = cyc % 8;
    if (bus_a.write_capture_valid || cap_due[idx]) begin
      check("cap_valid", bus_a.write_capture_valid, cap_due[idx]);
      if (cap_due[idx]) check("cap_data", bus_a.write_capture_data, pat(cap_tag[idx], cap_hl[idx]));
      cap_cnt++;
    end
    cap_due[idx] = 1'b0;
    if (bus_a.buffer_read_valid) begin
      br_q.push_back('{bus_a.buffer_read_tag, bus_a.buffer_read_address, cyc});
      cap_due[(cyc + BRLAT) % 8] = 1'b1;
      cap_tag[(cyc + BRLAT) % 8] = bus_a.buffer_read_tag;
      cap_hl[(cyc + BRLAT) % 8]  = bus_a.buffer_read_address[0];
    end
    if (bus_a.buffer_write_valid)
      bw_q.push_back('{bus_a.buffer_write_tag, bus_a.buffer_write_address, bus_a.buffer_write_data, cyc});
    if (bus_a.response_valid)
      resp_q.push_back('{bus_a.response_tag, bus_a.response_code, bus_a.response_credits, cyc});
    if (bus_b.response_valid) resp_b_q.push_back(bus_b.response_tag);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input bit sel, input logic [7:0] tag, input logic [12:0] code,
                     input logic [63:0] addr, input logic [11:0] size);
    if (sel) begin
      bus_b.command_valid = 1'b1; bus_b.command_tag = tag; bus_b.command_code = code;
      bus_b.command_address = addr; bus_b.command_size = size;
    end else begin
      bus_a.command_valid = 1'b1; bus_a.command_tag = tag; bus_a.command_code = code;
      bus_a.command_address = addr; bus_a.command_size = size;
    end
  endtask

  task automatic idle_cmd();
    bus_a.command_valid = 1'b0;
    bus_b.command_valid = 1'b0;
  endtask

  task automatic clear_q();
    resp_q.delete(); bw_q.delete(); br_q.delete(); resp_b_q.delete();
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (resp_q.size() < n && k < 100) begin step(); k++; end
    check("resp_wait", resp_q.size(), n);
  endtask

  task automatic get_resp(output resp_t r);
    if (resp_q.size() > 0) r = resp_q.pop_front();
    else r = '{8'hFF, 8'hFF, 9'h1FF, -1};
  endtask

  // One command on bus_a, waits for its response and checks tag/code/latency
  task automatic single(input logic [7:0] tag, input logic [12:0] code, input logic [63:0] addr,
                        input logic [11:0] size, input logic [7:0] exp_code, input int exp_lat);
    int    c;
    resp_t r;
    clear_q();
    step(); put(0, tag, code, addr, size); c = cyc;
    step(); idle_cmd();
    wait_resp(1);
    get_resp(r);
    check("resp_tag", r.tag, tag);
    check("resp_code", r.code, exp_code);
    check("resp_cred", r.cred, 9'd1);
    if (exp_lat > 0) check("resp_lat", r.cyc - c, exp_lat);
  endtask

  initial begin
    int    c;
    int    k;
    int    cap0;
    resp_t r;
    for (int i = 0; i < 8; i++) cap_due[i] = 1'b0;
    idle_cmd();
    bus_a.command_tag = 0; bus_a.command_code = 0; bus_a.command_address = 0; bus_a.command_size = 0;
    bus_b.command_tag = 0; bus_b.command_code = 0; bus_b.command_address = 0; bus_b.command_size = 0;
    bus_a.inject_valid = 0; bus_a.inject_code = 0; bus_b.inject_valid = 0; bus_b.inject_code = 0;
    bus_b.buffer_read_data = '0;
    bus_a.buffer_read_data = '0;
    repeat (3) step();
    check("rst_room", bus_a.room, 8'd64);
    check("rst_room_b", bus_b.room, 8'd4);
    check("rst_fifo", bus_a.fifo_count, 8'd0);
    check("rst_resp_v", bus_a.response_valid, 1'b0);
    check("rst_cerr", bus_a.credit_error, 1'b0);
    check("rst_bw_v", bus_a.buffer_write_valid, 1'b0);
    rstn = 1'b1;
    step();

    // READ_CL_NA: two buffer writes then DONE
    clear_q();
    step(); put(0, 8'h05, READ, 64'h1000, 12'd128); c = cyc;
    step(); idle_cmd();
    check("read_room_dec", bus_a.room, 8'd63);
    check("read_fifo_cnt", bus_a.fifo_count, 8'd1);
    wait_resp(1);
    get_resp(r);
    check("read_tag", r.tag, 8'h05);
    check("read_code", r.code, 8'h00);
    check("read_cred", r.cred, 9'd1);
    check("read_lat", r.cyc - c, 5);
    check("read_room_back", bus_a.room, 8'd64);
    check("read_bw_cnt", bw_q.size(), 2);
    if (bw_q.size() == 2) begin
      check("read_bw0_addr", bw_q[0].addr, 6'd0);
      check("read_bw0_data", bw_q[0].data, bwd(64'h1000, 1'b0));
      check("read_bw0_cyc", bw_q[0].cyc - c, 2);
      check("read_bw0_tag", bw_q[0].tag, 8'h05);
      check("read_bw1_addr", bw_q[1].addr, 6'd1);
      check("read_bw1_data", bw_q[1].data, bwd(64'h1000, 1'b1));
    end

    // WRITE_NA: two buffer reads, two captures, DONE 5+BRLAT after command
    clear_q();
    cap0 = cap_cnt;
    single(8'h07, WRITE, 64'h2000, 12'd128, 8'h00, 5 + BRLAT);
    check("write_br_cnt", br_q.size(), 2);
    if (br_q.size() == 2) begin
      check("write_br0_addr", br_q[0].addr, 6'd0);
      check("write_br1_addr", br_q[1].addr, 6'd1);
      check("write_br_tag", br_q[1].tag, 8'h07);
    end
    check("write_caps", cap_cnt - cap0, 2);
    check("write_no_bw", bw_q.size(), 0);

    single(8'h11, RESTART, 64'h0, 12'd0, 8'h00, 3);
    single(8'h21, READ, 64'h3000, 12'd64, 8'h01, 3);
    check("short_read_no_bw", bw_q.size(), 0);
    single(8'h22, 13'h0123, 64'h3000, 12'd128, 8'h01, 3);

    // Injected PAGED enters flush; RESTART leaves it
    clear_q();
    step(); bus_a.inject_valid = 1'b1; bus_a.inject_code = 8'h0A;
    step(); bus_a.inject_valid = 1'b0;
    put(0, 8'h31, READ, 64'h4000, 12'd128);
    step(); put(0, 8'h32, READ, 64'h4080, 12'd128);
    step(); put(0, 8'h33, RESTART, 64'h0, 12'd0);
    step(); idle_cmd();
    wait_resp(3);
    get_resp(r); check("inj_tag0", r.tag, 8'h31); check("inj_paged", r.code, 8'h0A);
    get_resp(r); check("inj_tag1", r.tag, 8'h32); check("inj_flushed", r.code, 8'h07);
    get_resp(r); check("inj_tag2", r.tag, 8'h33); check("inj_restart", r.code, 8'h00);
    check("flush_bw_cnt", bw_q.size(), 2);
    if (bw_q.size() == 2) check("flush_bw_tag", bw_q[1].tag, 8'h31);
    single(8'h34, READ, 64'h5000, 12'd128, 8'h00, 5);
    check("post_flush_bw", bw_q.size(), 2);

    // Later arm overwrites earlier one; override is one-shot
    step(); bus_a.inject_valid = 1'b1; bus_a.inject_code = 8'h03;
    step(); bus_a.inject_code = 8'h06;
    step(); bus_a.inject_valid = 1'b0;
    single(8'h41, RESTART, 64'h0, 12'd0, 8'h06, 3);
    single(8'h42, RESTART, 64'h0, 12'd0, 8'h00, 3);

    // Reset while waiting for the second halfline
    clear_q();
    step(); put(0, 8'h51, WRITE, 64'h6000, 12'd128);
    step(); idle_cmd();
    step(); step(); step();
    rstn = 1'b0;
    for (int i = 0; i < 8; i++) cap_due[i] = 1'b0;
    step(); step();
    rstn = 1'b1;
    repeat (15) step();
    check("rst_mid_no_resp", resp_q.size(), 0);
    check("rst_mid_room", bus_a.room, 8'd64);
    check("rst_mid_fifo", bus_a.fifo_count, 8'd0);
    single(8'h52, READ, 64'h7000, 12'd128, 8'h00, 5);
    check("rst_mid_next_bw", bw_q.size(), 2);

    // Credit exhaustion on the 4-credit instance
    clear_q();
    step();
    for (int i = 0; i < 5; i++) begin
      put(1, 8'h61 + 8'(i), READ, 64'h8000 + 64'(i * 128), 12'd128);
      check("cred_room", bus_b.room, 8'(4 - i));
      step();
    end
    idle_cmd();
    check("cred_error", bus_b.credit_error, 1'b1);
    k = 0;
    while (resp_b_q.size() < 4 && k < 100) begin step(); k++; end
    repeat (20) step();
    check("cred_resp_cnt", resp_b_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < resp_b_q.size()) check("cred_order", resp_b_q[i], 8'h61 + 8'(i));
    check("cred_room_back", bus_b.room, 8'd4);
    check("cred_error_sticky", bus_b.credit_error, 1'b1);
    check("cred_error_a", bus_a.credit_error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
